// File: rtl/serial_pattern_generator.sv
// Serializes parallel words MSB-first over a valid/ready load handshake.
// Optional emitted-pattern counter is compiled in with `GEN_PATTERN_COUNT_EN.
module serial_pattern_generator #(
  parameter int unsigned        WIDTH   = 8,
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sequence_out,
  output logic             out_valid,
  output logic             busy,
  output logic [7:0]       pattern_count
);

  localparam int unsigned         CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32 || PAT_LEN < 2 || PAT_LEN > 8 || PAT_LEN > WIDTH ||
      $bits(PATTERN) != PAT_LEN) begin : g_bad_cfg
    $error("serial_pattern_generator: unsupported WIDTH/PAT_LEN/PATTERN combination");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               handshake;

  // Serializer next-state and state-decoded outputs
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    load_ready   = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    sequence_out = 1'b0;
    handshake    = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        handshake  = load_valid;
        if (handshake) begin
          shift_d = data_in;
          cnt_d   = LAST_IDX;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid    = 1'b1;
        busy         = 1'b1;
        sequence_out = shift_q[WIDTH-1];
        load_ready   = (cnt_q == '0);
        handshake    = load_valid && load_ready;
        shift_d      = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d        = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          // Last bit: reload for a gap-free next word, otherwise drain to IDLE
          if (handshake) begin
            shift_d = data_in;
            cnt_d   = LAST_IDX;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef GEN_PATTERN_COUNT_EN
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [7:0]         count_q, count_d;

  // History only advances on real data bits, so idle gaps are transparent
  always_comb begin
    hist_d  = hist_q;
    count_d = count_q;
    if (out_valid) begin
      hist_d = {hist_q[PAT_LEN-2:0], sequence_out};
      if (hist_d == PATTERN && count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q  <= '0;
      count_q <= '0;
    end else begin
      hist_q  <= hist_d;
      count_q <= count_d;
    end
  end

  assign pattern_count = count_q;
`else
  assign pattern_count = 8'd0;
`endif

endmodule
